// File: rtl/mv_pkg.sv
// Shared types and constants for the matrix coefficient loader.
package mv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COEF   = 2'd1,
        CSUM   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [7:0] MV_HDR    = 8'hA5;
    localparam logic [1:0] ERR_CSUM  = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

endpackage

// File: rtl/mv_coef_loader.sv
// Byte-stream coefficient loader: validates a framed matrix, commits it atomically to matrix_out.
// Latency: commit/reject pulse one cycle after the checksum byte; in_ready drops only in the COMMIT cycle.
module mv_coef_loader
    import mv_pkg::*;
#(
    parameter int ROWS    = 3,
    parameter int COLS    = 4,
    parameter int COEF_W  = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [ROWS*COLS*COEF_W-1:0]   matrix_out,
    output logic                          matrix_valid,
    output logic                          load_done,
    output logic                          load_err,
    output logic [1:0]                    err_code
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int MAT_W = N * COEF_W;
    // Bits of a coefficient byte that must be zero for the value to be in range.
    localparam logic [7:0] RANGE_MASK = 8'hFF << COEF_W;

    state_t             state, state_nxt;
    logic               accept;
    logic               in_frame;
    logic               tmo;
    logic               last_coef;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         csum;
    logic               range_err;
    logic               csum_err;
    logic [CNT_W-1:0]   idle_cnt;
    logic [MAT_W-1:0]   shadow;

    assign accept    = in_valid & in_ready;
    assign in_frame  = (state == COEF) || (state == CSUM);
    assign last_coef = (idx == IDX_W'(N - 1));
    // An accepted byte on the deadline cycle pre-empts the timeout.
    assign tmo       = in_frame && !accept && (idle_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && in_data == MV_HDR) state_nxt = COEF;
            COEF:    if (tmo) state_nxt = IDLE;
                     else if (accept && last_coef) state_nxt = CSUM;
            CSUM:    if (tmo) state_nxt = IDLE;
                     else if (accept) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state != COMMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            csum         <= '0;
            range_err    <= 1'b0;
            csum_err     <= 1'b0;
            idle_cnt     <= '0;
            shadow       <= '0;
            matrix_out   <= '0;
            matrix_valid <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;

            if (in_frame && !accept && !tmo) idle_cnt <= idle_cnt + CNT_W'(1);
            else                             idle_cnt <= '0;

            if (tmo) begin
                load_err <= 1'b1;
                err_code <= ERR_TMO;
            end

            case (state)
                IDLE: if (accept && in_data == MV_HDR) begin
                    idx       <= '0;
                    csum      <= '0;
                    range_err <= 1'b0;
                end
                COEF: if (accept) begin
                    shadow[int'(idx)*COEF_W +: COEF_W] <= in_data[COEF_W-1:0];
                    csum      <= csum ^ in_data;
                    range_err <= range_err | (|(in_data & RANGE_MASK));
                    idx       <= idx + IDX_W'(1);
                end
                CSUM: if (accept) csum_err <= (in_data != csum);
                COMMIT: begin
                    if (range_err) begin
                        load_err <= 1'b1;
                        err_code <= ERR_RANGE;
                    end else if (csum_err) begin
                        load_err <= 1'b1;
                        err_code <= ERR_CSUM;
                    end else begin
                        matrix_out   <= shadow;
                        matrix_valid <= 1'b1;
                        load_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
